// File: rtl/mem_latency_responder.sv
// Word-addressed memory server for a val/rdy req/resp interface: fixed-latency,
// in-order responses, and credit-based backpressure on the request side.
module mem_latency_responder #(
    parameter int p_opaq_bits  = 8,
    parameter int p_num_words  = 1024,
    parameter int p_latency    = 2,
    parameter int p_resp_depth = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic                   req_op,
    input  logic [p_opaq_bits-1:0] req_opaque,
    input  logic [31:0]            req_addr,
    input  logic [3:0]             req_strb,
    input  logic [31:0]            req_data,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic                   resp_op,
    output logic [p_opaq_bits-1:0] resp_opaque,
    output logic [31:0]            resp_addr,
    output logic [31:0]            resp_data
);

    localparam int AW = $clog2(p_num_words);
    localparam int EW = 1 + p_opaq_bits + 64;
    localparam int PW = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;
    localparam int CW = $clog2(p_resp_depth + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(p_resp_depth);
    localparam logic [PW-1:0] LAST_C  = PW'(p_resp_depth - 1);

    logic [31:0]   mem_q [p_num_words];
    logic          req_fire;
    logic          resp_fire;
    logic [AW-1:0] idx;
    logic [EW-1:0] entry_in;
    logic          push;
    logic [EW-1:0] push_entry;
    logic [CW-1:0] out_q, out_d;
    logic [EW-1:0] fifo_q [p_resp_depth];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    // The credit counter covers the delay line and the FIFO together, so the
    // FIFO can never be pushed while it is full.
    assign req_rdy   = !rst && (out_q < DEPTH_C);
    assign resp_val  = (cnt_q != '0);
    assign req_fire  = req_val && req_rdy;
    assign resp_fire = resp_val && resp_rdy;
    assign idx       = req_addr[AW+1:2];
    assign entry_in  = {req_op, req_opaque, req_addr, req_op ? 32'h0 : mem_q[idx]};
    assign {resp_op, resp_opaque, resp_addr, resp_data} = fifo_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (req_fire && req_op) begin
            for (int i = 0; i < 4; i++) begin
                if (req_strb[i]) mem_q[idx][8*i +: 8] <= req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        out_d = out_q;
        if (req_fire && !resp_fire)      out_d = out_q + 1'b1;
        else if (!req_fire && resp_fire) out_d = out_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end

    generate
        if (p_latency == 1) begin : g_nodl
            assign push       = req_fire;
            assign push_entry = entry_in;
        end else begin : g_dl
            logic [p_latency-2:0] dl_val_q;
            logic [EW-1:0]        dl_ent_q [p_latency-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dl_val_q <= '0;
                    for (int i = 0; i < p_latency - 1; i++) dl_ent_q[i] <= '0;
                end else begin
                    dl_val_q[0] <= req_fire;
                    dl_ent_q[0] <= entry_in;
                    for (int i = 1; i < p_latency - 1; i++) begin
                        dl_val_q[i] <= dl_val_q[i-1];
                        dl_ent_q[i] <= dl_ent_q[i-1];
                    end
                end
            end

            assign push       = dl_val_q[p_latency-2];
            assign push_entry = dl_ent_q[p_latency-2];
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (push && !resp_fire)      cnt_d = cnt_q + 1'b1;
        else if (!push && resp_fire) cnt_d = cnt_q - 1'b1;
    end

    // Storage is cleared on reset so the response fields read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < p_resp_depth; i++) fifo_q[i] <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_entry;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (resp_fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    a_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !resp_fire && cnt_q == DEPTH_C));
    a_fifo_underflow: assert property (@(posedge clk) disable iff (rst)
        !(resp_fire && cnt_q == '0));
    a_out_range: assert property (@(posedge clk) disable iff (rst)
        out_q <= DEPTH_C);
    a_resp_stable: assert property (@(posedge clk) disable iff (rst)
        resp_val && !resp_rdy |=> resp_val &&
        $stable({resp_op, resp_opaque, resp_addr, resp_data}));

    function automatic string trace();
        string s_req;
        string s_resp;
        s_req  = req_fire ? $sformatf("%s:%08h", req_op ? "W" : "R", req_addr) : "          ";
        s_resp = resp_fire ? $sformatf("%08h", resp_data) : "        ";
        return {s_req, " | ", s_resp};
    endfunction
`endif

endmodule

// File: tb/tb_mem_latency_responder.sv
// Bench for mem_latency_responder: table-driven write/read vectors, then
// backpressure, streaming and mid-flight reset sequences against a scoreboard.
module tb_mem_latency_responder;

    localparam int L = 2;

    logic        clk;
    logic        rst;
    logic        req_val;
    logic        req_rdy;
    logic        req_op;
    logic [7:0]  req_opaque;
    logic [31:0] req_addr;
    logic [3:0]  req_strb;
    logic [31:0] req_data;
    logic        resp_val;
    logic        resp_rdy;
    logic        resp_op;
    logic [7:0]  resp_opaque;
    logic [31:0] resp_addr;
    logic [31:0] resp_data;

    mem_latency_responder #(
        .p_opaq_bits (8),
        .p_num_words (1024),
        .p_latency   (L),
        .p_resp_depth(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_op     (req_op),
        .req_opaque (req_opaque),
        .req_addr   (req_addr),
        .req_strb   (req_strb),
        .req_data   (req_data),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_op    (resp_op),
        .resp_opaque(resp_opaque),
        .resp_addr  (resp_addr),
        .resp_data  (resp_data)
    );

    typedef struct {
        logic        op;
        logic [7:0]  opq;
        logic [31:0] addr;
        logic [31:0] data;
        int          acc;
    } exp_t;

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [7:0]  opq;
        logic [31:0] exp_data;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[14];
    logic [31:0] ref_mem [1024];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          resp_count = 0;
    int          last_resp_cyc = 0;
    bit          chk_lat = 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Fires are decided by values stable at the falling edge; the fire edge is cyc+1.
    always @(negedge clk) begin
        exp_t e;
        if (resp_val === 1'b1 && resp_rdy === 1'b1) begin
            resp_count++;
            last_resp_cyc = cyc + 1;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL resp_unexpected: got op %b opq %h addr %h data %h, expected no response",
                         resp_op, resp_opaque, resp_addr, resp_data);
            end else begin
                e = sb.pop_front();
                if (resp_op !== e.op || resp_opaque !== e.opq || resp_addr !== e.addr ||
                    resp_data !== e.data) begin
                    n_fail++;
                    $display("FAIL resp_fields: got op %b opq %h addr %h data %h, expected op %b opq %h addr %h data %h",
                             resp_op, resp_opaque, resp_addr, resp_data, e.op, e.opq, e.addr, e.data);
                end
                if (chk_lat) chk("resp_latency", 32'(cyc + 1 - e.acc), 32'(L));
            end
        end
    end

    task automatic issue(input logic op, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] data, input logic [7:0] opq,
                         input logic [31:0] exp, output int acc);
        exp_t e;
        bit   ok;
        ok  = 0;
        acc = -1;
        req_val    = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_strb   = strb;
        req_data   = data;
        req_opaque = opq;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (req_rdy === 1'b1) begin
                ok     = 1;
                acc    = cyc + 1;
                e.op   = op;
                e.opq  = opq;
                e.addr = addr;
                e.data = exp;
                e.acc  = acc;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        req_val = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_accept: got no req_rdy in 200 cycles, expected accept of addr %h", addr);
        end else if (op) begin
            for (int i = 0; i < 4; i++)
                if (strb[i]) ref_mem[addr[11:2]][8*i +: 8] = data[8*i +: 8];
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int acc;
        int a0;
        int a1;
        int rc0;

        rst = 1'b0; resp_rdy = 1'b1; req_val = 1'b0; req_op = 1'b0;
        req_opaque = '0; req_addr = '0; req_strb = '0; req_data = '0;

        vecs[0]  = '{1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 8'h01, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0100, 4'h0, 32'h0,         8'h02, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0104, 4'hF, 32'hFFFF_FFFF, 8'h03, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0104, 4'h1, 32'h0000_0012, 8'h04, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0104, 4'h0, 32'h0,         8'h05, 32'hFFFF_FF12};
        vecs[5]  = '{1'b1, 32'h0000_1000, 4'hF, 32'hAAAA_5555, 8'h06, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         8'h07, 32'hAAAA_5555};
        vecs[7]  = '{1'b1, 32'h0000_0108, 4'hF, 32'h1122_3344, 8'h08, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0108, 4'h0, 32'h5566_7788, 8'h09, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0108, 4'hF, 32'h9999_9999, 8'h0A, 32'h1122_3344};
        vecs[10] = '{1'b1, 32'h0000_010C, 4'hF, 32'h0000_0000, 8'h0B, 32'h0};
        vecs[11] = '{1'b1, 32'h0000_010C, 4'hA, 32'hCAFE_F00D, 8'h0C, 32'h0};
        vecs[12] = '{1'b0, 32'h0000_010C, 4'h0, 32'h0,         8'h0D, 32'hCA00_F000};
        vecs[13] = '{1'b0, 32'h0000_0103, 4'h0, 32'h0,         8'hFE, 32'hDEAD_BEEF};

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_rdy", 32'(req_rdy), 32'd0);
        chk("reset_resp_val", 32'(resp_val), 32'd0);
        chk("reset_resp_data", resp_data, 32'd0);
        chk("reset_resp_addr", resp_addr, 32'd0);
        chk("reset_resp_opaque", 32'(resp_opaque), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_req_rdy", 32'(req_rdy), 32'd1);

        for (int i = 0; i < 14; i++)
            issue(vecs[i].op, vecs[i].addr, vecs[i].strb, vecs[i].data, vecs[i].opq,
                  vecs[i].exp_data, acc);
        drain();

        for (int i = 0; i < 32; i++)
            issue(1'b1, 32'h400 + 32'(4 * i), 4'hF, 32'hC0DE_0000 + 32'(i) * 32'h0001_0001,
                  8'h40, 32'h0, acc);
        drain();

        // Backpressure: only four requests may be outstanding while responses stall.
        chk_lat  = 0;
        resp_rdy = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    issue(1'b0, 32'h400 + 32'(4 * i), 4'h0, 32'h0, 8'(i),
                          ref_mem[10'(256 + i)], acc);
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                chk("bp_accepted", 32'(sb.size()), 32'd4);
                chk("bp_req_rdy", 32'(req_rdy), 32'd0);
                chk("bp_resp_val", 32'(resp_val), 32'd1);
                chk("bp_resp_opaque_held", 32'(resp_opaque), 32'd0);
                resp_rdy = 1'b1;
            end
        join
        drain();
        chk_lat = 1;

        rc0 = resp_count;
        a0  = 0;
        a1  = 0;
        for (int i = 0; i < 32; i++) begin
            issue(1'b0, 32'h400 + 32'(4 * i), 4'h0, 32'h0, 8'(8'h80 + i),
                  ref_mem[10'(256 + i)], acc);
            if (i == 0) a0 = acc;
            a1 = acc;
        end
        drain();
        chk("stream_back_to_back", 32'(a1 - a0), 32'd31);
        chk("stream_resp_count", 32'(resp_count - rc0), 32'd32);
        chk("stream_resp_span", 32'(last_resp_cyc - a0), 32'(31 + L));

        // Reset with three reads in flight.
        resp_rdy = 1'b0;
        for (int i = 0; i < 3; i++)
            issue(1'b0, 32'h400 + 32'(4 * i), 4'h0, 32'h0, 8'(8'hC0 + i),
                  ref_mem[10'(256 + i)], acc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_resp_val", 32'(resp_val), 32'd0);
        chk("midrst_req_rdy", 32'(req_rdy), 32'd0);
        chk("midrst_resp_data", resp_data, 32'd0);
        chk("midrst_resp_opaque", 32'(resp_opaque), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        resp_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("postrst_no_stale", 32'(resp_val), 32'd0);
        end
        @(posedge clk);
        #1;
        issue(1'b0, 32'h100, 4'h0, 32'h0, 8'hD0, ref_mem[10'h040], acc);
        issue(1'b0, 32'h404, 4'h0, 32'h0, 8'hD1, ref_mem[10'h101], acc);
        drain();
        chk("postrst_storage_kept", ref_mem[10'h040], 32'hDEAD_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected finish before 200000");
        $fatal(1);
    end

endmodule
